axi_ram_slave: RTL and testbench

- On-chip AXI4 slave RAM that consumes the AXI master port of the CPU cache/memory subsystem, serving I-cache refills, D-cache refills/write-backs and uncached accesses.
- Backed by a single-port synchronous word RAM.
- Serves one transaction at a time: a read burst or a write burst, with arbitration between the AR and AW channels.

---
 rtl/axi_ram_slave_if.sv | 63 ++++++
 rtl/axi_ram_slave.sv | 199 +++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between the cache/memory subsystem master and the on-chip RAM slave.
// Carries the five AXI channels (AR, R, AW, W, B) with full-word data and byte strobes.
interface axi_ram_slave_if #(
   parameter int ID_WIDTH = 4
);
   logic [ID_WIDTH-1:0] arid;
   logic [31:0]         araddr;
   logic [7:0]          arlen;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;

   logic [ID_WIDTH-1:0] rid;
   logic [31:0]         rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   logic [ID_WIDTH-1:0] awid;
   logic [31:0]         awaddr;
   logic [7:0]          awlen;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;

   logic [31:0]         wdata;
   logic [3:0]          wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [ID_WIDTH-1:0] bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output arid, araddr, arlen, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_ram_slave.sv
// On-chip AXI4 RAM slave serving one burst at a time from a single-port word RAM.
// Reads and writes are arbitrated round-robin in IDLE; FIXED, INCR and WRAP bursts
// share one word-address sequencer. Upper address bits beyond ADDR_WIDTH alias.
module axi_ram_slave #(
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32
) (
   input logic            i_clk,
   input logic            i_rst,
   axi_ram_slave_if.slave axi
);
   localparam int WA    = ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << WA;

   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

   state_t              state_q;
   logic [ID_WIDTH-1:0] id_q;
   logic [WA-1:0]       addr_q;
   logic [WA-1:0]       addr_d;
   logic [7:0]          len_q;
   logic [1:0]          burst_q;
   logic [8:0]          issued_q;
   logic [7:0]          beat_q;
   logic                err_q;
   logic                lastGrantWr_q;

   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rvalid_q;
   logic                  rlast_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic arGrant;
   logic awGrant;
   logic rdIssue;
   logic wBeat;
   logic beatLast;
   logic wErr;
   logic unusedAddrBits;

   // Next word address for the active burst: hold, increment, or wrap within an aligned block.
   function automatic logic [WA-1:0] advance(input logic [WA-1:0] a,
                                             input logic [7:0]    len,
                                             input logic [1:0]    burst);
      logic [WA-1:0] inc;
      logic [WA-1:0] mask;
      logic [WA-1:0] res;
      inc       = a + WA'(1);
      mask      = '0;
      mask[3:0] = len[3:0];
      res       = inc;
      if (burst == 2'b00) begin
         res = a;
      end else if (burst == 2'b10) begin
         if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) begin
            res = (a & ~mask) | (inc & mask);
         end
      end
      return res;
   endfunction

   // Grant logic: only in IDLE and out of reset; ties go to the channel not served last time.
   always_comb begin
      arGrant = 1'b0;
      awGrant = 1'b0;
      if (!i_rst && state_q == IDLE) begin
         if (axi.arvalid && (!axi.awvalid || lastGrantWr_q)) begin
            arGrant = 1'b1;
         end else if (axi.awvalid) begin
            awGrant = 1'b1;
         end
      end
   end

   // Per-cycle burst events: read issue, write beat acceptance and wlast consistency.
   always_comb begin
      addr_d   = advance(addr_q, len_q, burst_q);
      rdIssue  = (state_q == RD) && (issued_q <= {1'b0, len_q}) && (!rvalid_q || axi.rready);
      wBeat    = !i_rst && (state_q == WR) && axi.wvalid && wready_q;
      beatLast = (beat_q == len_q);
      wErr     = (axi.wlast != beatLast);
   end

   // RAM write port: only the strobed bytes of the current word are updated.
   always_ff @(posedge i_clk) begin
      if (wBeat) begin
         for (int b = 0; b < 4; b++) begin
            if (axi.wstrb[b]) begin
               mem[addr_q][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
         end
      end
   end

   // Transaction FSM with registered R/W/B outputs; the RAM read port feeds rdata directly.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= IDLE;
         id_q          <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         burst_q       <= '0;
         issued_q      <= '0;
         beat_q        <= '0;
         err_q         <= 1'b0;
         lastGrantWr_q <= 1'b1;
         rdata_q       <= '0;
         rvalid_q      <= 1'b0;
         rlast_q       <= 1'b0;
         wready_q      <= 1'b0;
         bvalid_q      <= 1'b0;
         bresp_q       <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (arGrant) begin
                  id_q          <= axi.arid;
                  addr_q        <= axi.araddr[ADDR_WIDTH-1:2];
                  len_q         <= axi.arlen;
                  burst_q       <= axi.arburst;
                  issued_q      <= '0;
                  lastGrantWr_q <= 1'b0;
                  state_q       <= RD;
               end else if (awGrant) begin
                  id_q          <= axi.awid;
                  addr_q        <= axi.awaddr[ADDR_WIDTH-1:2];
                  len_q         <= axi.awlen;
                  burst_q       <= axi.awburst;
                  beat_q        <= '0;
                  err_q         <= 1'b0;
                  wready_q      <= 1'b1;
                  lastGrantWr_q <= 1'b1;
                  state_q       <= WR;
               end
            end
            RD: begin
               if (rdIssue) begin
                  rdata_q  <= mem[addr_q];
                  rvalid_q <= 1'b1;
                  rlast_q  <= (issued_q[7:0] == len_q);
                  issued_q <= issued_q + 9'd1;
                  addr_q   <= addr_d;
               end else if (rvalid_q && axi.rready) begin
                  rvalid_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  if (rlast_q) begin
                     state_q <= IDLE;
                  end
               end
            end
            WR: begin
               if (wBeat) begin
                  addr_q <= addr_d;
                  beat_q <= beat_q + 8'd1;
                  if (wErr) begin
                     err_q <= 1'b1;
                  end
                  if (beatLast) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= (err_q || wErr) ? 2'b10 : 2'b00;
                     state_q  <= WRESP;
                  end
               end
            end
            WRESP: begin
               if (axi.bready) begin
                  bvalid_q <= 1'b0;
                  bresp_q  <= 2'b00;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign unusedAddrBits = ^{axi.araddr[31:ADDR_WIDTH], axi.araddr[1:0],
                             axi.awaddr[31:ADDR_WIDTH], axi.awaddr[1:0]};

   assign axi.arready = arGrant;
   assign axi.awready = awGrant;
   assign axi.rid     = id_q;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = 2'b00;
   assign axi.rlast   = rlast_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.wready  = wready_q;
   assign axi.bid     = id_q;
   assign axi.bresp   = bresp_q;
   assign axi.bvalid  = bvalid_q;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: single and partial writes, INCR/WRAP/FIXED bursts,
// R back-pressure, round-robin arbitration, wlast errors and reset in mid-burst.
module tb_axi_ram_slave;
   logic i_clk = 1'b0;
   logic i_rst;

   always #5 i_clk = ~i_clk;

   axi_ram_slave_if #(.ID_WIDTH(4)) bus ();

   axi_ram_slave #(.ADDR_WIDTH(16), .ID_WIDTH(4), .DATA_WIDTH(32)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .axi   (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] wrBuf [16];
   logic [31:0] rdBuf [16];
   logic        rlastBuf [16];
   logic [3:0]  ridBuf [16];
   int          beatCycle [16];
   int          rdCount;
   int          stallViolations;

   // Hard stop in case a handshake never completes.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic idleInputs();
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
   endtask

   // Full AW/W/B transaction; beat b carries wrBuf[b], wlast raised on beat lastBeat only.
   task automatic doWrite(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [3:0] strb, input int lastBeat,
                          output logic [1:0] resp, output logic [3:0] bidOut, output bit timedOut);
      int n;
      timedOut = 1'b0;
      resp     = 2'b11;
      bidOut   = 4'h0;
      @(negedge i_clk);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
      #1;
      n = 0;
      while (!bus.awready && n < 100) begin @(negedge i_clk); #1; n++; end
      if (!bus.awready) begin timedOut = 1'b1; bus.awvalid = 1'b0; return; end
      @(posedge i_clk);
      @(negedge i_clk);
      bus.awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         bus.wdata = wrBuf[b]; bus.wstrb = strb; bus.wlast = (b == lastBeat); bus.wvalid = 1'b1;
         #1;
         n = 0;
         while (!bus.wready && n < 100) begin @(negedge i_clk); #1; n++; end
         if (!bus.wready) begin timedOut = 1'b1; bus.wvalid = 1'b0; return; end
         @(posedge i_clk);
         @(negedge i_clk);
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
      #1;
      n = 0;
      while (!bus.bvalid && n < 100) begin @(negedge i_clk); #1; n++; end
      if (!bus.bvalid) begin timedOut = 1'b1; bus.bready = 1'b0; return; end
      resp   = bus.bresp;
      bidOut = bus.bid;
      @(posedge i_clk);
      @(negedge i_clk);
      bus.bready = 1'b0;
   endtask

   // Full AR/R transaction; beats land in rdBuf/rlastBuf/ridBuf, stalls are checked for stability.
   task automatic doRead(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input bit toggle, output bit timedOut);
      int          n;
      int          cyc;
      bit          done;
      bit          prevStall;
      logic [31:0] prevData;
      logic        prevLast;
      logic [3:0]  prevId;
      rdCount = 0; stallViolations = 0; timedOut = 1'b0; done = 1'b0; prevStall = 1'b0;
      prevData = '0; prevLast = 1'b0; prevId = '0;
      @(negedge i_clk);
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
      #1;
      n = 0;
      while (!bus.arready && n < 100) begin @(negedge i_clk); #1; n++; end
      if (!bus.arready) begin timedOut = 1'b1; bus.arvalid = 1'b0; return; end
      @(posedge i_clk);
      @(negedge i_clk);
      bus.arvalid = 1'b0;
      cyc = 0;
      while (cyc < 200 && !done) begin
         bus.rready = toggle ? (cyc % 2 == 0) : 1'b1;
         #1;
         if (prevStall) begin
            if (!bus.rvalid || bus.rdata !== prevData || bus.rlast !== prevLast || bus.rid !== prevId)
               stallViolations++;
         end
         prevStall = bus.rvalid && !bus.rready;
         prevData  = bus.rdata; prevLast = bus.rlast; prevId = bus.rid;
         if (bus.rvalid && bus.rready) begin
            if (rdCount < 16) begin
               rdBuf[rdCount] = bus.rdata; rlastBuf[rdCount] = bus.rlast;
               ridBuf[rdCount] = bus.rid; beatCycle[rdCount] = cyc;
            end
            rdCount++;
            if (bus.rlast) done = 1'b1;
         end
         @(posedge i_clk);
         @(negedge i_clk);
         cyc++;
      end
      bus.rready = 1'b0;
      if (!done) timedOut = 1'b1;
   endtask

   // Presents AR and AW together, serves whichever is granted, and watches the loser's ready.
   task automatic tieGrant(output int granted, output bit loserReadySeen, output bit timedOut);
      int n;
      granted = 0; loserReadySeen = 1'b0; timedOut = 1'b0;
      @(negedge i_clk);
      bus.arid = 4'h3; bus.araddr = 32'h100; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arvalid = 1'b1;
      bus.awid = 4'h6; bus.awaddr = 32'h700; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
      #1;
      n = 0;
      while (!bus.arready && !bus.awready && n < 100) begin @(negedge i_clk); #1; n++; end
      if (bus.arready && bus.awready) loserReadySeen = 1'b1;
      if (bus.arready) granted = 1;
      else if (bus.awready) granted = 2;
      else begin timedOut = 1'b1; bus.arvalid = 1'b0; bus.awvalid = 1'b0; return; end
      @(posedge i_clk);
      @(negedge i_clk);
      if (granted == 1) begin
         bus.arvalid = 1'b0; bus.rready = 1'b1;
         n = 0;
         while (n < 100) begin
            #1;
            if (bus.awready) loserReadySeen = 1'b1;
            if (bus.rvalid) break;
            @(negedge i_clk);
            n++;
         end
         if (!bus.rvalid) timedOut = 1'b1;
         @(posedge i_clk);
         @(negedge i_clk);
         bus.awvalid = 1'b0; bus.rready = 1'b0;
      end else begin
         bus.awvalid = 1'b0;
         bus.wdata = 32'h7777_0000; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
         #1;
         if (bus.arready) loserReadySeen = 1'b1;
         @(posedge i_clk);
         @(negedge i_clk);
         bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
         n = 0;
         while (n < 100) begin
            #1;
            if (bus.arready) loserReadySeen = 1'b1;
            if (bus.bvalid) break;
            @(negedge i_clk);
            n++;
         end
         if (!bus.bvalid) timedOut = 1'b1;
         @(posedge i_clk);
         @(negedge i_clk);
         bus.arvalid = 1'b0; bus.bready = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      idleInputs();
      bus.arvalid = 1'b1; bus.awvalid = 1'b1;
      repeat (2) @(negedge i_clk);
      #1;
      vectors++;
      if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs_in_reset got %b want %b",
                  {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}, 5'b0);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      bus.arvalid = 1'b0; bus.awvalid = 1'b0;
      #1;
      vectors++;
      if ({bus.rdata, bus.rlast, bus.bresp, bus.rid, bus.bid} !== 43'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_data_outputs got %h want %h",
                  {bus.rdata, bus.rlast, bus.bresp, bus.rid, bus.bid}, 43'b0);
      end
   endtask

   task automatic test_single_rw();
      logic [1:0] resp;
      logic [3:0] bidOut;
      bit         to;
      wrBuf[0] = 32'hDEAD_BEEF;
      doWrite(32'h100, 8'd0, 2'b01, 4'h5, 4'hF, 0, resp, bidOut, to);
      vectors++;
      if ({to, resp, bidOut} !== {1'b0, 2'b00, 4'h5}) begin
         miscompares++;
         $display("[TB] FAIL single_write timeout/bresp/bid got %b/%b/%h want 0/00/5", to, resp, bidOut);
      end
      doRead(32'h100, 8'd0, 2'b01, 4'hA, 1'b0, to);
      vectors++;
      if ({to, rdCount[4:0], rdBuf[0], rlastBuf[0], ridBuf[0]} !== {1'b0, 5'd1, 32'hDEAD_BEEF, 1'b1, 4'hA}) begin
         miscompares++;
         $display("[TB] FAIL single_read to=%b beats=%0d data=%h last=%b rid=%h want 0/1/deadbeef/1/a",
                  to, rdCount, rdBuf[0], rlastBuf[0], ridBuf[0]);
      end
      vectors++;
      if (bus.rresp !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL rresp got %b want 00", bus.rresp);
      end
   endtask

   task automatic test_partial_strobe();
      logic [1:0] resp;
      logic [3:0] bidOut;
      bit         to1, to2, to3;
      wrBuf[0] = 32'h1122_3344;
      doWrite(32'h20, 8'd0, 2'b01, 4'h1, 4'b1111, 0, resp, bidOut, to1);
      wrBuf[0] = 32'hAABB_CCDD;
      doWrite(32'h20, 8'd0, 2'b01, 4'h1, 4'b0101, 0, resp, bidOut, to2);
      doRead(32'h20, 8'd0, 2'b01, 4'h2, 1'b0, to3);
      vectors++;
      if ({to1, to2, to3, rdBuf[0]} !== {3'b000, 32'h11BB_33DD}) begin
         miscompares++;
         $display("[TB] FAIL partial_strobe to=%b%b%b got %h want 11bb33dd", to1, to2, to3, rdBuf[0]);
      end
   endtask

   task automatic test_incr_burst();
      logic [1:0] resp;
      logic [3:0] bidOut;
      bit         to;
      for (int k = 0; k < 16; k++) wrBuf[k] = 32'hA000_0000 + k;
      doWrite(32'h400, 8'd15, 2'b01, 4'h7, 4'hF, 15, resp, bidOut, to);
      vectors++;
      if ({to, resp, bidOut} !== {1'b0, 2'b00, 4'h7}) begin
         miscompares++;
         $display("[TB] FAIL incr_write to/bresp/bid got %b/%b/%h want 0/00/7", to, resp, bidOut);
      end
      doRead(32'h400, 8'd15, 2'b01, 4'hC, 1'b0, to);
      vectors++;
      if (to !== 1'b0 || rdCount != 16) begin
         miscompares++;
         $display("[TB] FAIL incr_read_beats to=%b got %0d want 16", to, rdCount);
      end
      for (int k = 0; k < 16; k++) begin
         vectors++;
         if ({rdBuf[k], rlastBuf[k], ridBuf[k]} !== {32'hA000_0000 + 32'(k), (k == 15), 4'hC}) begin
            miscompares++;
            $display("[TB] FAIL incr_beat%0d got %h/%b/%h want %h/%b/c", k, rdBuf[k], rlastBuf[k],
                     ridBuf[k], 32'hA000_0000 + 32'(k), (k == 15));
         end
         vectors++;
         if (beatCycle[k] != beatCycle[0] + k) begin
            miscompares++;
            $display("[TB] FAIL incr_rate beat%0d got cycle %0d want %0d", k, beatCycle[k], beatCycle[0] + k);
         end
      end
      doRead(32'h400, 8'd15, 2'b01, 4'hD, 1'b1, to);
      vectors++;
      if (to !== 1'b0 || rdCount != 16 || stallViolations != 0) begin
         miscompares++;
         $display("[TB] FAIL stall_read to=%b beats=%0d unstable=%0d want 0/16/0", to, rdCount, stallViolations);
      end
      for (int k = 0; k < 16; k++) begin
         vectors++;
         if ({rdBuf[k], rlastBuf[k]} !== {32'hA000_0000 + 32'(k), (k == 15)}) begin
            miscompares++;
            $display("[TB] FAIL stall_beat%0d got %h/%b want %h/%b", k, rdBuf[k], rlastBuf[k],
                     32'hA000_0000 + 32'(k), (k == 15));
         end
      end
   endtask

   task automatic test_wrap_fixed();
      logic [1:0]  resp;
      logic [3:0]  bidOut;
      bit          to;
      logic [31:0] expWrap [4];
      logic [31:0] expOdd  [3];
      expWrap[0] = 32'hA000_0002; expWrap[1] = 32'hA000_0003;
      expWrap[2] = 32'hA000_0000; expWrap[3] = 32'hA000_0001;
      doRead(32'h408, 8'd3, 2'b10, 4'h4, 1'b0, to);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (to !== 1'b0 || rdBuf[k] !== expWrap[k] || rlastBuf[k] !== (k == 3)) begin
            miscompares++;
            $display("[TB] FAIL wrap_beat%0d to=%b got %h/%b want %h/%b", k, to, rdBuf[k], rlastBuf[k],
                     expWrap[k], (k == 3));
         end
      end
      expOdd[0] = 32'hA000_0002; expOdd[1] = 32'hA000_0003; expOdd[2] = 32'hA000_0004;
      doRead(32'h408, 8'd2, 2'b10, 4'h4, 1'b0, to);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (to !== 1'b0 || rdBuf[k] !== expOdd[k]) begin
            miscompares++;
            $display("[TB] FAIL wrap_len2_as_incr beat%0d got %h want %h", k, rdBuf[k], expOdd[k]);
         end
      end
      doRead(32'h404, 8'd2, 2'b00, 4'h4, 1'b0, to);
      vectors++;
      if ({to, rdCount[4:0], rdBuf[0], rdBuf[1], rdBuf[2]} !==
          {1'b0, 5'd3, 32'hA000_0001, 32'hA000_0001, 32'hA000_0001}) begin
         miscompares++;
         $display("[TB] FAIL fixed_read got %h %h %h want a0000001 x3", rdBuf[0], rdBuf[1], rdBuf[2]);
      end
      wrBuf[0] = 32'h5A5A_0001; wrBuf[1] = 32'h5A5A_0002;
      doWrite(32'hFFFC, 8'd1, 2'b01, 4'h2, 4'hF, 1, resp, bidOut, to);
      doRead(32'h0, 8'd0, 2'b01, 4'h2, 1'b0, to);
      vectors++;
      if (to !== 1'b0 || rdBuf[0] !== 32'h5A5A_0002) begin
         miscompares++;
         $display("[TB] FAIL incr_wrap_ram_end got %h want 5a5a0002", rdBuf[0]);
      end
      doRead(32'h0001_FFFC, 8'd0, 2'b01, 4'h2, 1'b0, to);
      vectors++;
      if (to !== 1'b0 || rdBuf[0] !== 32'h5A5A_0001) begin
         miscompares++;
         $display("[TB] FAIL alias_upper_bits got %h want 5a5a0001", rdBuf[0]);
      end
   endtask

   task automatic test_arbitration();
      int g;
      bit seen, to;
      int expGrant [4];
      expGrant[0] = 1; expGrant[1] = 2; expGrant[2] = 1; expGrant[3] = 2;
      @(negedge i_clk);
      i_rst = 1'b1;
      idleInputs();
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      for (int t = 0; t < 4; t++) begin
         tieGrant(g, seen, to);
         vectors++;
         if (to !== 1'b0 || g != expGrant[t] || seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tie%0d grant got %0d (loserReady=%b to=%b) want %0d (loserReady=0)",
                     t, g, seen, to, expGrant[t]);
         end
      end
   endtask

   task automatic test_wlast_error();
      logic [1:0] resp;
      logic [3:0] bidOut;
      bit         to;
      wrBuf[0] = 32'h6000_0000; wrBuf[1] = 32'h6000_0001;
      wrBuf[2] = 32'h6000_0002; wrBuf[3] = 32'h6000_0003;
      doWrite(32'h600, 8'd3, 2'b01, 4'h9, 4'hF, 1, resp, bidOut, to);
      vectors++;
      if ({to, resp, bidOut} !== {1'b0, 2'b10, 4'h9}) begin
         miscompares++;
         $display("[TB] FAIL early_wlast to/bresp/bid got %b/%b/%h want 0/10/9", to, resp, bidOut);
      end
      doRead(32'h600, 8'd3, 2'b01, 4'h9, 1'b0, to);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (to !== 1'b0 || rdBuf[k] !== 32'h6000_0000 + 32'(k)) begin
            miscompares++;
            $display("[TB] FAIL early_wlast_data beat%0d got %h want %h", k, rdBuf[k], 32'h6000_0000 + 32'(k));
         end
      end
      wrBuf[0] = 32'h6800_0000;
      doWrite(32'h680, 8'd0, 2'b01, 4'hB, 4'hF, -1, resp, bidOut, to);
      vectors++;
      if ({to, resp} !== {1'b0, 2'b10}) begin
         miscompares++;
         $display("[TB] FAIL missing_wlast to/bresp got %b/%b want 0/10", to, resp);
      end
      wrBuf[0] = 32'h6900_0000; wrBuf[1] = 32'h6900_0001;
      doWrite(32'h690, 8'd1, 2'b01, 4'hB, 4'hF, 1, resp, bidOut, to);
      vectors++;
      if ({to, resp} !== {1'b0, 2'b00}) begin
         miscompares++;
         $display("[TB] FAIL error_not_sticky to/bresp got %b/%b want 0/00", to, resp);
      end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      @(negedge i_clk);
      bus.arid = 4'h1; bus.araddr = 32'h400; bus.arlen = 8'd15; bus.arburst = 2'b01; bus.arvalid = 1'b1;
      #1;
      n = 0;
      while (!bus.arready && n < 100) begin @(negedge i_clk); #1; n++; end
      @(posedge i_clk);
      @(negedge i_clk);
      bus.arvalid = 1'b0; bus.rready = 1'b1;
      repeat (3) @(negedge i_clk);
      #1;
      vectors++;
      if (bus.rvalid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midburst_active rvalid got %b want 1", bus.rvalid);
      end
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      vectors++;
      if ({bus.rvalid, bus.rlast} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL midburst_reset rvalid/rlast got %b want 00", {bus.rvalid, bus.rlast});
      end
      @(negedge i_clk);
      i_rst = 1'b0; bus.rready = 1'b0;
      bus.arid = 4'h2; bus.araddr = 32'h100; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arvalid = 1'b1;
      #1;
      vectors++;
      if (bus.arready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL post_reset_arready got %b want 1", bus.arready);
      end
      @(posedge i_clk);
      @(negedge i_clk);
      bus.arvalid = 1'b0; bus.rready = 1'b1;
      #1;
      n = 0;
      while (!bus.rvalid && n < 100) begin @(negedge i_clk); #1; n++; end
      vectors++;
      if ({bus.rvalid, bus.rdata, bus.rid} !== {1'b1, 32'hDEAD_BEEF, 4'h2}) begin
         miscompares++;
         $display("[TB] FAIL ram_kept_after_reset got %b/%h/%h want 1/deadbeef/2", bus.rvalid, bus.rdata, bus.rid);
      end
      @(posedge i_clk);
      @(negedge i_clk);
      bus.rready = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1;
      idleInputs();
      test_reset();
      test_single_rw();
      test_partial_strobe();
      test_incr_burst();
      test_wrap_fixed();
      test_arbitration();
      test_wlast_error();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
